// File: rtl/board_store.sv
// Board register for the 4x4 tile game plus a tear-free redraw streamer.
// Each frame is emitted from a shadow copy, one tile per accepted valid/ready handshake.
module board_store #(
  parameter  int TILE_W  = 4,
  parameter  int N_TILES = 16,
  localparam int BOARD_W = N_TILES * TILE_W,
  localparam int IDX_W   = $clog2(N_TILES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               update,
  input  logic [BOARD_W-1:0] newvalues,
  output logic [BOARD_W-1:0] oldvalues,
  input  logic               draw_req,
  input  logic               tile_ready,
  output logic               tile_valid,
  output logic [IDX_W-1:0]   tile_index,
  output logic [TILE_W-1:0]  tile_value,
  output logic               draw_busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BOARD_W-1:0] r_board;
  logic [BOARD_W-1:0] r_shadow;
  logic               r_dirty;
  logic [IDX_W-1:0]   r_idx;

  logic [BOARD_W-1:0] w_board_nxt;
  logic               w_changed;
  logic               w_last;
  logic               w_accept;
  logic [TILE_W-1:0]  w_tiles [N_TILES];

  assign w_board_nxt = update ? newvalues : r_board;
  assign w_changed   = update && (newvalues != r_board);
  assign w_last      = (r_idx == IDX_W'(N_TILES - 1));
  assign w_accept    = (r_state == SCAN) && tile_ready;

  // Tile 0 lives in the most significant nibble.
  for (genvar g = 0; g < N_TILES; g++) begin : g_tiles
    assign w_tiles[g] = r_shadow[BOARD_W-1-g*TILE_W -: TILE_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (r_dirty || draw_req) w_state_nxt = LOAD;
      LOAD: w_state_nxt = SCAN;
      SCAN: if (tile_ready && w_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset leaves dirty set so an empty board is drawn once reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_board  <= '0;
      r_shadow <= '0;
      r_dirty  <= 1'b1;
      r_idx    <= '0;
    end else begin
      r_board <= w_board_nxt;
      if (r_state == LOAD) begin
        r_shadow <= w_board_nxt;
        r_idx    <= '0;
      end else if (w_accept && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      // A changing update wins over the clear taken in LOAD.
      if (w_changed) begin
        r_dirty <= 1'b1;
      end else if (r_state == LOAD) begin
        r_dirty <= 1'b0;
      end
    end
  end

  assign oldvalues  = r_board;
  assign tile_valid = (r_state == SCAN);
  assign tile_index = r_idx;
  assign tile_value = w_tiles[r_idx];
  assign draw_busy  = (r_state != IDLE);
  assign frame_done = (r_state == DONE);

endmodule
